// File: rtl/axis_hdr_pkg.sv
// Shared types and byte/keep helpers for the header-extraction datapath.
// Optional feature macro used by the top: AXIS_EXTRACT_ERR_EN.
package axis_hdr_pkg;

    // Widest beat (in bytes) the keep helpers can describe.
    localparam int unsigned MaxBytes = 64;

    typedef enum logic [1:0] {
        StHdr,
        StBody,
        StFlush
    } state_e;

    // MSB-contiguous keep: the top cnt bytes of an nbytes-wide beat.
    function automatic logic [MaxBytes-1:0] cnt_to_keep_msb(input int cnt, input int nbytes);
        logic [MaxBytes-1:0] keep;
        keep = '0;
        for (int i = 0; i < MaxBytes; i++) begin
            if (i < nbytes && i >= nbytes - cnt) keep[i] = 1'b1;
        end
        return keep;
    endfunction

    // LSB-contiguous keep: the bottom cnt bytes.
    function automatic logic [MaxBytes-1:0] cnt_to_keep_lsb(input int cnt);
        logic [MaxBytes-1:0] keep;
        keep = '0;
        for (int i = 0; i < MaxBytes; i++) begin
            if (i < cnt) keep[i] = 1'b1;
        end
        return keep;
    endfunction

    function automatic int keep_to_cnt(input logic [MaxBytes-1:0] keep);
        int cnt;
        cnt = 0;
        for (int i = 0; i < MaxBytes; i++) begin
            if (keep[i]) cnt = cnt + 1;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/axis_byte_merge.sv
// Combinational byte merge: splices the held residual (MSB-aligned, R = BYTES - N bytes)
// in front of the first N bytes of a beat, and returns the beat's tail as the new residual.
module axis_byte_merge #(
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic [DATA_WD-1:0]   res_i,
    input  logic [DATA_WD-1:0]   beat_i,
    input  logic [BYTE_CNT_WD:0] beat_cnt_i,
    input  logic [BYTE_CNT_WD:0] n_i,
    output logic [DATA_WD-1:0]   merged_o,
    output logic [BYTE_CNT_WD:0] merged_cnt_o,
    output logic [DATA_WD-1:0]   res_o,
    output logic [BYTE_CNT_WD:0] res_cnt_o
);

    localparam int unsigned CntW  = BYTE_CNT_WD + 1;
    localparam int          Bytes = int'(DATA_BYTE_WD);

    int n_bytes;
    int k_bytes;
    int r_bytes;

    // Merge residual with beat head; beat tail becomes the next residual
    always_comb begin
        n_bytes  = int'(n_i);
        k_bytes  = int'(beat_cnt_i);
        r_bytes  = Bytes - n_bytes;
        merged_o = res_i | (beat_i >> (8 * r_bytes));
        if (r_bytes + k_bytes > Bytes) begin
            merged_cnt_o = CntW'(Bytes);
        end else begin
            merged_cnt_o = CntW'(r_bytes + k_bytes);
        end
        res_o = beat_i << (8 * n_bytes);
        if (k_bytes > n_bytes) begin
            res_cnt_o = CntW'(k_bytes - n_bytes);
        end else begin
            res_cnt_o = '0;
        end
    end

endmodule

// File: rtl/axi_stream_extract_header.sv
// Strips an N-byte header off each AXI-Stream packet onto its own channel and re-aligns
// the payload to the MSB byte. Define AXIS_EXTRACT_ERR_EN to enable err_short detection.
module axi_stream_extract_header
    import axis_hdr_pkg::*;
#(
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    input  logic [BYTE_CNT_WD:0]    byte_extract_cnt,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    output logic                    valid_header,
    input  logic                    ready_header,
    output logic [DATA_WD-1:0]      data_header,
    output logic [DATA_BYTE_WD-1:0] keep_header,
    output logic                    err_short
);

    localparam int unsigned CntW  = BYTE_CNT_WD + 1;
    localparam int          Bytes = int'(DATA_BYTE_WD);

    function automatic logic [DATA_BYTE_WD-1:0] keep_msb(input int cnt);
        logic [MaxBytes-1:0] full;
        full = cnt_to_keep_msb(cnt, Bytes);
        return full[DATA_BYTE_WD-1:0];
    endfunction

    function automatic logic [DATA_BYTE_WD-1:0] keep_lsb(input int cnt);
        logic [MaxBytes-1:0] full;
        full = cnt_to_keep_lsb(cnt);
        return full[DATA_BYTE_WD-1:0];
    endfunction

    state_e                  state_q, state_d;
    logic [CntW-1:0]         n_q, n_d;
    logic [DATA_WD-1:0]      res_q, res_d;
    logic [CntW-1:0]         res_cnt_q, res_cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WD-1:0]      out_data_q, out_data_d;
    logic [DATA_BYTE_WD-1:0] out_keep_q, out_keep_d;
    logic                    out_last_q, out_last_d;
    logic                    hdr_valid_q, hdr_valid_d;
    logic [DATA_WD-1:0]      hdr_data_q, hdr_data_d;
    logic [DATA_BYTE_WD-1:0] hdr_keep_q, hdr_keep_d;

    logic [MaxBytes-1:0] keep_ext;
    logic [DATA_WD-1:0]  beat;
    logic [CntW-1:0]     beat_cnt;
    logic [CntW-1:0]     n_in;
    logic [CntW-1:0]     n_sel;
    logic [DATA_WD-1:0]  merged;
    logic [CntW-1:0]     merged_cnt;
    logic [DATA_WD-1:0]  res_new;
    logic [CntW-1:0]     res_new_cnt;
    logic                pay_free;
    logic                hdr_free;
    logic                accept;
    int                  k_bytes;
    int                  n_bytes;
    int                  h_bytes;

    // Ingress: blank bytes outside keep, count them, clamp N to the beat width
    always_comb begin
        keep_ext = '0;
        keep_ext[DATA_BYTE_WD-1:0] = keep_in;
        beat = '0;
        for (int i = 0; i < Bytes; i++) begin
            beat[8*i +: 8] = keep_in[i] ? data_in[8*i +: 8] : 8'h00;
        end
        beat_cnt = CntW'(keep_to_cnt(keep_ext));
        n_in     = (int'(byte_extract_cnt) > Bytes) ? CntW'(Bytes) : byte_extract_cnt;
        n_sel    = (state_q == StHdr) ? n_in : n_q;
        k_bytes  = int'(beat_cnt);
        n_bytes  = int'(n_sel);
        h_bytes  = (k_bytes < n_bytes) ? k_bytes : n_bytes;
    end

    axis_byte_merge #(
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD),
        .BYTE_CNT_WD  (BYTE_CNT_WD)
    ) u_merge (
        .res_i        (res_q),
        .beat_i       (beat),
        .beat_cnt_i   (beat_cnt),
        .n_i          (n_sel),
        .merged_o     (merged),
        .merged_cnt_o (merged_cnt),
        .res_o        (res_new),
        .res_cnt_o    (res_new_cnt)
    );

    // Output slots free up when empty or draining this cycle
    assign pay_free = !out_valid_q || ready_out;
    assign hdr_free = !hdr_valid_q || ready_header;
    assign ready_in = rst_n && (state_q != StFlush) && pay_free &&
                      ((state_q != StHdr) || hdr_free);
    assign accept   = valid_in && ready_in;

    // Next-state for the FSM, residual and both output channels
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        res_d       = res_q;
        res_cnt_d   = res_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        hdr_valid_d = hdr_valid_q;
        hdr_data_d  = hdr_data_q;
        hdr_keep_d  = hdr_keep_q;
        if (out_valid_q && ready_out) out_valid_d = 1'b0;
        if (hdr_valid_q && ready_header) hdr_valid_d = 1'b0;

        unique case (state_q)
            StHdr: begin
                if (accept) begin
                    n_d       = n_sel;
                    res_d     = res_new;
                    res_cnt_d = res_new_cnt;
                    if (n_bytes > 0) begin
                        // Truncated headers stay right-aligned on the bytes actually seen
                        hdr_valid_d = 1'b1;
                        hdr_data_d  = beat >> (8 * (Bytes - h_bytes));
                        hdr_keep_d  = keep_lsb(h_bytes);
                    end
                    if (!last_in) begin
                        state_d = StBody;
                    end else if (k_bytes > n_bytes) begin
                        out_valid_d = 1'b1;
                        out_data_d  = res_new;
                        out_keep_d  = keep_msb(k_bytes - n_bytes);
                        out_last_d  = 1'b1;
                    end
                end
            end
            StBody: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_data_d  = merged;
                    out_keep_d  = keep_msb(int'(merged_cnt));
                    out_last_d  = last_in && (k_bytes <= n_bytes);
                    res_d       = res_new;
                    res_cnt_d   = res_new_cnt;
                    if (last_in) state_d = (k_bytes > n_bytes) ? StFlush : StHdr;
                end
            end
            StFlush: begin
                if (pay_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = res_q;
                    out_keep_d  = keep_msb(int'(res_cnt_q));
                    out_last_d  = 1'b1;
                    res_d       = '0;
                    res_cnt_d   = '0;
                    state_d     = StHdr;
                end
            end
            default: state_d = StHdr;
        endcase
    end

    // FSM and registered outputs, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StHdr;
            n_q         <= '0;
            res_q       <= '0;
            res_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            hdr_valid_q <= 1'b0;
            hdr_data_q  <= '0;
            hdr_keep_q  <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            res_q       <= res_d;
            res_cnt_q   <= res_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            hdr_valid_q <= hdr_valid_d;
            hdr_data_q  <= hdr_data_d;
            hdr_keep_q  <= hdr_keep_d;
        end
    end

    assign valid_out    = out_valid_q;
    assign data_out     = out_data_q;
    assign keep_out     = out_keep_q;
    assign last_out     = out_last_q;
    assign valid_header = hdr_valid_q;
    assign data_header  = hdr_data_q;
    assign keep_header  = hdr_keep_q;

`ifdef AXIS_EXTRACT_ERR_EN
    logic err_q, err_d;

    // A packet that ends on its first beat with fewer bytes than N is short
    always_comb err_d = accept && (state_q == StHdr) && last_in && (beat_cnt < n_sel);

    // One-cycle pulse register
    always_ff @(posedge clk) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err_short = err_q;
`else
    assign err_short = 1'b0;
`endif

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Scoreboard bench for axi_stream_extract_header (DATA_WD = 32).
module tb_axi_stream_extract_header;

    localparam int BW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic        ready_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        last_in;
    logic [2:0]  byte_extract_cnt;
    logic        valid_out;
    logic        ready_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;
    logic        valid_header;
    logic        ready_header;
    logic [31:0] data_header;
    logic [3:0]  keep_header;
    logic        err_short;

    always #5 clk = ~clk;

    axi_stream_extract_header #(
        .DATA_WD (32)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .valid_in         (valid_in),
        .ready_in         (ready_in),
        .data_in          (data_in),
        .keep_in          (keep_in),
        .last_in          (last_in),
        .byte_extract_cnt (byte_extract_cnt),
        .valid_out        (valid_out),
        .ready_out        (ready_out),
        .data_out         (data_out),
        .keep_out         (keep_out),
        .last_out         (last_out),
        .valid_header     (valid_header),
        .ready_header     (ready_header),
        .data_header      (data_header),
        .keep_header      (keep_header),
        .err_short        (err_short)
    );

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    beat_t pay_q[$];
    beat_t hdr_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    err_seen = 0;
    int    err_exp = 0;
    int    stall_pct = 0;
    int    gap_max = 0;
    logic  force_lo_out = 1'b0;
    logic  force_lo_hdr = 1'b0;

    function automatic logic [31:0] kmask(input logic [3:0] k);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < BW; i++) if (k[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got no event, expected one within the cycle budget", name);
    endtask

    // Reference: header = first min(N,len) bytes right-aligned; the rest chunked MSB-first.
    task automatic model_pkt(input int n, input logic [7:0] b[$]);
        beat_t e;
        int    nc;
        int    h;
        int    cnt;
        nc = (n > BW) ? BW : n;
        h  = (nc < b.size()) ? nc : b.size();
        if (nc > b.size()) err_exp++;
        if (nc > 0) begin
            e.d = '0;
            e.k = '0;
            e.l = 1'b0;
            for (int i = 0; i < h; i++) begin
                e.d[8*(h-1-i) +: 8] = b[i];
                e.k[i] = 1'b1;
            end
            hdr_q.push_back(e);
        end
        for (int p = h; p < b.size(); p += BW) begin
            cnt = (b.size() - p < BW) ? b.size() - p : BW;
            e.d = '0;
            e.k = '0;
            for (int j = 0; j < cnt; j++) begin
                e.d[8*(BW-1-j) +: 8] = b[p+j];
                e.k[BW-1-j] = 1'b1;
            end
            e.l = (p + BW >= b.size());
            pay_q.push_back(e);
        end
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                              input logic [2:0] n);
        int cyc;
        cyc = 0;
        valid_in = 1'b1;
        data_in = d;
        keep_in = k;
        last_in = l;
        byte_extract_cnt = n;
        forever begin
            @(negedge clk);
            if (ready_in) break;
            cyc++;
            if (cyc > 1000) begin
                fail_now("ready_in timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic send_pkt(input int n, input logic [7:0] b[$]);
        int          cnt;
        logic [31:0] d;
        logic [3:0]  k;
        model_pkt(n, b);
        for (int p = 0; p < b.size(); p += BW) begin
            cnt = (b.size() - p < BW) ? b.size() - p : BW;
            d = $urandom();
            k = '0;
            for (int j = 0; j < cnt; j++) begin
                d[8*(BW-1-j) +: 8] = b[p+j];
                k[BW-1-j] = 1'b1;
            end
            drive_beat(d, k, (p + BW >= b.size()), 3'(n));
            if (gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((pay_q.size() != 0 || hdr_q.size() != 0) && c < 2000) begin
            @(posedge clk);
            c++;
        end
        if (c >= 2000) fail_now("scoreboard drain");
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Sink readiness, refreshed just after each edge
    initial begin
        ready_out = 1'b0;
        ready_header = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ready_out    = force_lo_out ? 1'b0 : ($urandom_range(0, 99) >= stall_pct);
            ready_header = force_lo_hdr ? 1'b0 : ($urandom_range(0, 99) >= stall_pct);
        end
    end

    // Monitor: compare on handshake, check stall stability, count err pulses
    initial begin
        beat_t e;
        beat_t pprev;
        beat_t hprev;
        logic  pprev_v;
        logic  hprev_v;
        pprev_v = 1'b0;
        hprev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pprev_v = 1'b0;
                hprev_v = 1'b0;
            end else begin
                if (pprev_v) begin
                    chk("valid_out held", 32'(valid_out), 32'd1);
                    chk("data_out held", data_out, pprev.d);
                    chk("keep_out held", 32'(keep_out), 32'(pprev.k));
                end
                if (hprev_v) begin
                    chk("valid_header held", 32'(valid_header), 32'd1);
                    chk("data_header held", data_header, hprev.d);
                end
                pprev_v = valid_out && !ready_out;
                pprev.d = data_out;
                pprev.k = keep_out;
                hprev_v = valid_header && !ready_header;
                hprev.d = data_header;
                if (valid_out && ready_out) begin
                    if (pay_q.size() == 0) begin
                        fail_now("payload beat with empty scoreboard");
                    end else begin
                        e = pay_q.pop_front();
                        chk("keep_out", 32'(keep_out), 32'(e.k));
                        chk("last_out", 32'(last_out), 32'(e.l));
                        chk("data_out", data_out & kmask(e.k), e.d & kmask(e.k));
                    end
                end
                if (valid_header && ready_header) begin
                    if (hdr_q.size() == 0) begin
                        fail_now("header beat with empty scoreboard");
                    end else begin
                        e = hdr_q.pop_front();
                        chk("keep_header", 32'(keep_header), 32'(e.k));
                        chk("data_header", data_header & kmask(e.k), e.d & kmask(e.k));
                    end
                end
                if (err_short) err_seen++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected one before the time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s1[$];
        logic [7:0] s3[$];
        logic [7:0] s4[$];
        logic [7:0] rb[$];
        logic [31:0] hold;
        int          e0;
        int          cyc;
        int          len;

        s1 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        s3 = '{8'hAA, 8'hBB};
        s4 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

        rst_n = 1'b0;
        valid_in = 1'b0;
        data_in = '0;
        keep_in = '0;
        last_in = 1'b0;
        byte_extract_cnt = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ready_in during reset", 32'(ready_in), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset valid_out", 32'(valid_out), 32'd0);
        chk("reset valid_header", 32'(valid_header), 32'd0);
        chk("reset last_out", 32'(last_out), 32'd0);
        chk("reset data_out", data_out, 32'd0);
        chk("reset keep_out", 32'(keep_out), 32'd0);
        chk("reset data_header", data_header, 32'd0);
        chk("reset keep_header", 32'(keep_header), 32'd0);
        chk("reset err_short", 32'(err_short), 32'd0);
        @(posedge clk);
        #1;

        send_pkt(2, s1);
        drain();
        send_pkt(1, s1);
        drain();
        send_pkt(4, s4);
        drain();
        e0 = err_seen;
        send_pkt(3, s3);
        drain();
`ifdef AXIS_EXTRACT_ERR_EN
        chk("err_short pulses on short packet", 32'(err_seen - e0), 32'd1);
`else
        chk("err_short stays low", 32'(err_seen - e0), 32'd0);
`endif

        // Payload sink stalled mid-packet
        force_lo_out = 1'b1;
        ready_out = 1'b0;
        fork
            send_pkt(1, s1);
            begin
                cyc = 0;
                while (!valid_out && cyc < 100) begin
                    @(negedge clk);
                    cyc++;
                end
                if (cyc >= 100) fail_now("payload valid under stall");
                hold = data_out;
                repeat (3) begin
                    @(negedge clk);
                    chk("ready_in low while payload stalled", 32'(ready_in), 32'd0);
                    chk("data_out stable while stalled", data_out, hold);
                end
                force_lo_out = 1'b0;
            end
        join
        drain();

        // Header sink stalled blocks the next packet's first beat
        force_lo_hdr = 1'b1;
        ready_header = 1'b0;
        send_pkt(4, s4);
        fork
            send_pkt(2, s1);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("ready_in low while header pending", 32'(ready_in), 32'd0);
                end
                force_lo_hdr = 1'b0;
            end
        join
        drain();

        // Reset in the middle of a packet
        force_lo_out = 1'b1;
        force_lo_hdr = 1'b1;
        ready_out = 1'b0;
        ready_header = 1'b0;
        drive_beat(32'hAABBCCDD, 4'hF, 1'b0, 3'd2);
        drive_beat(32'h11223344, 4'hF, 1'b0, 3'd2);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("valid_out after mid-packet reset", 32'(valid_out), 32'd0);
        chk("valid_header after mid-packet reset", 32'(valid_header), 32'd0);
        force_lo_out = 1'b0;
        force_lo_hdr = 1'b0;
        @(posedge clk);
        #1;
        send_pkt(2, s1);
        drain();

        // Randomized packets, header lengths and back-pressure
        stall_pct = 30;
        gap_max = 1;
        for (int p = 0; p < 200; p++) begin
            len = $urandom_range(1, 13);
            rb.delete();
            for (int i = 0; i < len; i++) rb.push_back(8'($urandom()));
            send_pkt($urandom_range(0, 7), rb);
        end
        stall_pct = 0;
        gap_max = 0;
        drain();
`ifdef AXIS_EXTRACT_ERR_EN
        chk("err_short pulse total", 32'(err_seen), 32'(err_exp));
`else
        chk("err_short pulse total", 32'(err_seen), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
